lfsr_decryptor: RTL and testbench
=================================

# lfsr_decryptor

Hardware decryption engine that consumes the output of the program-1 encryption stage. It reads the 64-byte ciphertext block from data memory, identifies the LFSR tap pattern and seed from the known all-space preamble, and writes the recovered 7-bit biased plaintext back to memory. It sits on the data-memory port beside the core and uses the same init/req/ack launch handshake as top_level.

## Interface
- CT_BASE, 64: first ciphertext address (64 bytes, CT_BASE..CT_BASE+63)
- PT_BASE, 0: first plaintext output address (64 bytes)
- META_BASE, 128: metadata output; +0 taps, +1 seed, +2 status
- PRE_MIN, 10: guaranteed minimum preamble length, in characters
- clk  input  1  single clock, rising edge
- init  input  1  synchronous active-high reset
- req  input  1  high = hold idle; the run launches on the first cycle with init=0 and req=0
- ack  output  1  run complete; held high until init
- mem_addr  output  8  data-memory address
- mem_wr_en  output  1  write strobe; the write commits at the next rising edge
- mem_wdata  output  8  write data
- mem_rdata  input  8  combinational read data for the current mem_addr

## Operation
- Ciphertext model:
  - ct[i] = (pt[i] ^ lfsr[i]) & 0x7F; bit 7 is ignored on read.
  - The space character is biased to 0x00, so preamble ciphertext equals the LFSR state.
  - LFSR step: next = {s[5:0], ^(s & taps)}, 7-bit.
- States: IDLE → LOAD → SEARCH → DEC_RD ⇄ DEC_WR → META → DONE. Failure path: SEARCH → FAIL → DONE.
- IDLE: no memory activity. Leaves on init=0 and req=0.
- LOAD: 10 cycles. Reads CT_BASE..CT_BASE+9, one per cycle, into a 10×7 preamble buffer.
- SEARCH: tests pattern index k = 0..8 from the package ROM, one index per cycle.
  - A match requires step(buf[j], taps[k]) == buf[j+1] for all j = 0..8.
  - On the first match, exit with k; the lowest index wins when several patterns match.
  - If buf[0] == 0 (illegal seed), or no index matches after 9 cycles, go to FAIL.
- DEC_RD / DEC_WR, repeated for n = 0..63:
  - DEC_RD reads CT_BASE+n.
  - DEC_WR writes PT_BASE+n with (ct ^ lfsr) & 0x7F.
  - The LFSR starts at buf[0] and steps once per completed byte.
- META: 3 write cycles.
  - META_BASE+0 = 0x60..0x7B (the matched taps value).
  - META_BASE+1 = seed.
  - META_BASE+2 = 0x00.
- FAIL: 3 write cycles.
  - META_BASE+0 = 0x00.
  - META_BASE+1 = buf[0].
  - META_BASE+2 = 0xFF.
  - No plaintext is written.
- DONE: ack=1, no memory activity. The state is held regardless of req; only init leaves DONE.

## Timing
- Reset values: ack=0, mem_wr_en=0, mem_addr=0, mem_wdata=0. State resets to IDLE.
- Cycle 0 is the first cycle with init=0 and req=0. LOAD occupies cycles 0–9.
- Success path: ack rises 142+k cycles after cycle 0.
  - 10 (LOAD) + (k+1) (SEARCH) + 128 (DEC) + 3 (META).
- Failure path: ack rises after 10 + 9 + 3 = 22 cycles; after 11 + 3 = 14 cycles when seed is 0.
- Exactly one memory access per cycle. mem_wr_en is high only in DEC_WR, META and FAIL.
- req toggling after launch is ignored until the next init.
- init mid-run: the state is IDLE after that edge, and there are no further writes. Bytes already written are not restored.
- Address arithmetic is 8-bit. Parameters must keep all addresses ≤ 255; no wrap-around is expected.

## Structure
- Package lfsr_pkg:
  - LFSR_PTRN[9] = 60, 48, 78, 72, 6A, 69, 5C, 7E, 7B.
  - lfsr_step function.
  - State enum.
  - Status constants ST_OK = 0x00, ST_FAIL = 0xFF.
- Sub-module lfsr_match: combinational. Takes the 10×7 buffer and taps; returns a 1-bit match using 9 parallel step comparisons.

## Test plan
- Pattern 0x60, seed 0x01, pre_length 10, "Mr. Watson, come here. I want to see you." encrypted by the program-1 model:
  - PT[0..9] = 0x00, PT[10] = 0x2D, PT[63] = 0x00.
  - META = 60/01/00.
  - ack at cycle 142.
- Pattern 0x7B (k=8), seed 0x5A, pre_length 26, random 28-char string:
  - All 64 plaintext bytes match the model.
  - META = 7B/5A/00.
  - ack at cycle 150.
- Ciphertext block all 0x00 (seed 0):
  - META = 00/00/FF.
  - PT region untouched.
  - ack at cycle 14.
- Corrupted ct[5] (bit 0 flipped) with otherwise valid data:
  - No pattern matches; META+2 = 0xFF.
  - ack at cycle 22.
- init asserted at cycle 60 of a valid run:
  - Next cycle: mem_wr_en = 0 and ack = 0.
  - Relaunching gives a correct full result.
- req held high for 50 cycles after init drops:
  - mem_wr_en stays 0 and ack stays 0.
  - The run completes normally after req falls.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types, tap-pattern ROM and the LFSR step function for the decryptor.
package lfsr_pkg;

  localparam int unsigned NUM_PTRN  = 9;
  localparam int unsigned PRE_MIN   = 10;
  localparam int unsigned BLOCK_LEN = 64;

  localparam logic [7:0] ST_OK   = 8'h00;
  localparam logic [7:0] ST_FAIL = 8'hFF;

  // Index 0 sits in the least significant slot, so it is listed last.
  localparam logic [NUM_PTRN-1:0][6:0] LFSR_PTRN = {
    7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
  };

  typedef logic [PRE_MIN-1:0][6:0] pre_buf_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_DEC_RD,
    S_DEC_WR,
    S_META,
    S_FAIL,
    S_DONE
  } state_e;

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
    return {s[5:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr_decryptor_if.sv
// Launch handshake plus data-memory port shared by the decryptor and its host.
interface lfsr_decryptor_if;
  logic       req;
  logic       ack;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    input  req, mem_rdata,
    output ack, mem_addr, mem_wr_en, mem_wdata
  );

  modport slave (
    output req, mem_rdata,
    input  ack, mem_addr, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/lfsr_match.sv
// Checks whether one tap pattern explains every transition of the preamble buffer.
module lfsr_match
  import lfsr_pkg::*;
(
  input  pre_buf_t   pre_i,
  input  logic [6:0] taps_i,
  output logic       match_o
);

  logic [PRE_MIN-2:0] hit;

  for (genvar j = 0; j < PRE_MIN - 1; j++) begin : g_cmp
    assign hit[j] = (lfsr_step(pre_i[j], taps_i) == pre_i[j+1]);
  end

  assign match_o = &hit;

endmodule

// File: rtl/lfsr_decryptor.sv
// Recovers LFSR taps and seed from the all-space preamble, then decrypts the
// 64-byte ciphertext block and writes plaintext plus metadata back to memory.
module lfsr_decryptor
  import lfsr_pkg::*;
#(
  parameter logic [7:0] CT_BASE   = 8'd64,
  parameter logic [7:0] PT_BASE   = 8'd0,
  parameter logic [7:0] META_BASE = 8'd128
) (
  input  logic             clk,
  input  logic             init,
  lfsr_decryptor_if.master bus
);

  localparam logic [3:0] LD_LAST = 4'(PRE_MIN - 1);
  localparam logic [3:0] K_LAST  = 4'(NUM_PTRN - 1);
  localparam logic [5:0] N_LAST  = 6'(BLOCK_LEN - 1);

  state_e     state_q;
  pre_buf_t   pre_q;
  logic [3:0] ld_q;
  logic [3:0] k_q;
  logic [5:0] n_q;
  logic [1:0] m_q;
  logic [6:0] lfsr_q;
  logic [6:0] taps_q;
  logic       ack_q;
  logic       wr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;

  logic       match;
  logic [6:0] taps_cand;
  logic [6:0] seed;
  logic [6:0] pt_d;
  logic [6:0] lfsr_d;

  assign taps_cand = LFSR_PTRN[k_q];
  assign seed      = pre_q[0];
  assign pt_d      = bus.mem_rdata[6:0] ^ lfsr_q;
  assign lfsr_d    = lfsr_step(lfsr_q, taps_q);

  lfsr_match u_match (
    .pre_i   (pre_q),
    .taps_i  (taps_cand),
    .match_o (match)
  );

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      ld_q    <= '0;
      k_q     <= '0;
      n_q     <= '0;
      m_q     <= '0;
      lfsr_q  <= '0;
      taps_q  <= '0;
      ack_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.req) begin
            state_q <= S_LOAD;
            ld_q    <= '0;
            addr_q  <= CT_BASE;
          end
        end

        S_LOAD: begin
          // Shift in from the top so the first byte read ends up in slot 0.
          pre_q <= {bus.mem_rdata[6:0], pre_q[PRE_MIN-1:1]};
          if (ld_q == LD_LAST) begin
            state_q <= S_SEARCH;
            k_q     <= '0;
            addr_q  <= CT_BASE;
          end else begin
            ld_q   <= ld_q + 4'd1;
            addr_q <= addr_q + 8'd1;
          end
        end

        S_SEARCH: begin
          if (seed == '0 || (!match && k_q == K_LAST)) begin
            state_q <= S_FAIL;
            m_q     <= '0;
            wr_q    <= 1'b1;
            addr_q  <= META_BASE;
            wdata_q <= '0;
          end else if (match) begin
            state_q <= S_DEC_RD;
            taps_q  <= taps_cand;
            lfsr_q  <= seed;
            n_q     <= '0;
            addr_q  <= CT_BASE;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end

        S_DEC_RD: begin
          state_q <= S_DEC_WR;
          wr_q    <= 1'b1;
          addr_q  <= PT_BASE + {2'b00, n_q};
          wdata_q <= {1'b0, pt_d};
        end

        S_DEC_WR: begin
          lfsr_q <= lfsr_d;
          if (n_q == N_LAST) begin
            state_q <= S_META;
            m_q     <= '0;
            wr_q    <= 1'b1;
            addr_q  <= META_BASE;
            wdata_q <= {1'b0, taps_q};
          end else begin
            state_q <= S_DEC_RD;
            n_q     <= n_q + 6'd1;
            wr_q    <= 1'b0;
            addr_q  <= CT_BASE + {2'b00, n_q + 6'd1};
          end
        end

        // Both metadata paths share the seed/status sequence; word 0 is set on entry.
        S_META, S_FAIL: begin
          m_q    <= m_q + 2'd1;
          addr_q <= addr_q + 8'd1;
          unique case (m_q)
            2'd0: wdata_q <= {1'b0, seed};
            2'd1: wdata_q <= (state_q == S_META) ? ST_OK : ST_FAIL;
            default: begin
              state_q <= S_DONE;
              ack_q   <= 1'b1;
              wr_q    <= 1'b0;
              addr_q  <= '0;
              wdata_q <= '0;
            end
          endcase
        end

        S_DONE: ack_q <= 1'b1;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wr_en = wr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lfsr_decryptor.sv
// Scoreboard bench for lfsr_decryptor: expected memory writes are queued at
// stimulus time and checked by an independent write monitor.
module tb_lfsr_decryptor;

  localparam logic [7:0] CT_BASE   = 8'd64;
  localparam logic [7:0] PT_BASE   = 8'd0;
  localparam logic [7:0] META_BASE = 8'd128;

  logic clk = 1'b0;
  logic init;

  lfsr_decryptor_if bus ();

  lfsr_decryptor #(
    .CT_BASE   (CT_BASE),
    .PT_BASE   (PT_BASE),
    .META_BASE (META_BASE)
  ) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) mem <= img;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  logic [15:0] exp_q[$];
  logic [6:0]  pt_exp [64];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_seen  = 0;
  bit          sb_on    = 1'b0;

  // Write monitor: every DUT write is popped against the expected queue.
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      wr_seen++;
      if (sb_on) begin
        logic [15:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got addr %02h data %02h, expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_addr, bus.mem_wdata} !== e)
            begin
              n_fail++;
              $display("FAIL write_scoreboard: got addr %02h data %02h, expected addr %02h data %02h",
                       bus.mem_addr, bus.mem_wdata, e[15:8], e[7:0]);
            end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [6:0] m_step(input logic [6:0] s, input logic [6:0] t);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 7; i++) fb = fb ^ (s[i] & t[i]);
    return {s[5:0], fb};
  endfunction

  // Program-1 encryption model: space-biased text XOR LFSR stream.
  task automatic build(input logic [6:0] taps, input logic [6:0] seed,
                       input int pre_len, input string msg);
    logic [6:0] s;
    logic [7:0] ch;
    for (int i = 0; i < 256; i++) img[i] = 8'hA5;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      ch = 8'h20;
      if (i >= pre_len && (i - pre_len) < msg.len()) ch = msg[i - pre_len];
      pt_exp[i] = 7'(ch - 8'h20);
      img[CT_BASE + i] = {1'b0, pt_exp[i] ^ s};
      s = m_step(s, taps);
    end
  endtask

  task automatic expect_success(input logic [6:0] taps, input logic [6:0] seed);
    for (int i = 0; i < 64; i++) exp_q.push_back({8'(PT_BASE + i), 1'b0, pt_exp[i]});
    exp_q.push_back({META_BASE,        1'b0, taps});
    exp_q.push_back({META_BASE + 8'd1, 1'b0, seed});
    exp_q.push_back({META_BASE + 8'd2, 8'h00});
  endtask

  task automatic expect_failure(input logic [6:0] seed);
    exp_q.push_back({META_BASE,        8'h00});
    exp_q.push_back({META_BASE + 8'd1, 1'b0, seed});
    exp_q.push_back({META_BASE + 8'd2, 8'hFF});
  endtask

  task automatic do_init();
    @(posedge clk); #1;
    init    = 1'b1;
    bus.req = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_img();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Called 1 time unit after an edge; the next edge is cycle 0.
  task automatic launch_wait(input int exp_cyc, input string name);
    int cyc;
    cyc     = 0;
    init    = 1'b0;
    bus.req = 1'b0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) break;
      cyc++;
    end
    check({name, "_ack_cycle"}, cyc, exp_cyc);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_meta(input string name, input int t, input int s, input int st);
    check({name, "_meta_taps"},   mem[META_BASE],        t);
    check({name, "_meta_seed"},   mem[META_BASE + 8'd1], s);
    check({name, "_meta_status"}, mem[META_BASE + 8'd2], st);
  endtask

  task automatic check_pt_untouched(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[PT_BASE + i] !== 8'hA5) bad++;
    check({name, "_pt_untouched"}, bad, 0);
  endtask

  initial begin
    string msg1;
    string msg2;
    int    bad;
    int    wr0;
    msg1 = "Mr. Watson, come here. I want to see you.";
    msg2 = "Kq9#vB2!xZ7&mW4@rT8*nH5$pL0%";

    init    = 1'b1;
    bus.req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",   bus.ack,       0);
    check("reset_wr_en", bus.mem_wr_en, 0);
    check("reset_addr",  bus.mem_addr,  0);
    check("reset_wdata", bus.mem_wdata, 0);

    // Pattern 0x60, seed 0x01, ten-space preamble
    build(7'h60, 7'h01, 10, msg1);
    load_img();
    expect_success(7'h60, 7'h01);
    sb_on = 1'b1;
    launch_wait(142, "t1");
    for (int i = 0; i < 10; i++) check("t1_pt_preamble", mem[PT_BASE + i], 8'h00);
    check("t1_pt10", mem[PT_BASE + 10], 8'h2D);
    check("t1_pt63", mem[PT_BASE + 63], 8'h00);
    check_meta("t1", 8'h60, 8'h01, 8'h00);
    for (int i = 0; i < 8; i++) begin
      bus.req = ~bus.req;
      @(posedge clk); #1;
      check("t1_done_hold_ack", bus.ack, 1);
    end

    // Pattern 0x7B (k=8), seed 0x5A, bit 7 of odd ciphertext bytes set
    do_init();
    build(7'h7B, 7'h5A, 26, msg2);
    for (int i = 1; i < 64; i += 2) img[CT_BASE + i][7] = 1'b1;
    load_img();
    expect_success(7'h7B, 7'h5A);
    launch_wait(150, "t2");
    check_meta("t2", 8'h7B, 8'h5A, 8'h00);

    // All-zero ciphertext: illegal seed
    do_init();
    build(7'h60, 7'h00, 64, "");
    load_img();
    expect_failure(7'h00);
    launch_wait(14, "t3");
    check_meta("t3", 8'h00, 8'h00, 8'hFF);
    check_pt_untouched("t3");

    // Corrupted preamble byte: no pattern can match
    do_init();
    build(7'h60, 7'h01, 10, msg1);
    img[CT_BASE + 5] = img[CT_BASE + 5] ^ 8'h01;
    load_img();
    expect_failure(7'h01);
    launch_wait(22, "t4");
    check_meta("t4", 8'h00, 8'h01, 8'hFF);
    check_pt_untouched("t4");

    // Abort at cycle 60, hold req for 50 cycles, then relaunch
    do_init();
    build(7'h60, 7'h01, 10, msg1);
    load_img();
    sb_on   = 1'b0;
    init    = 1'b0;
    bus.req = 1'b0;
    repeat (61) @(posedge clk);
    #1;
    check("t5_cycle60_dec_write", bus.mem_wr_en, 1);
    init = 1'b1;
    @(posedge clk); #1;
    check("t5_abort_wr_en", bus.mem_wr_en, 0);
    check("t5_abort_ack",   bus.ack,       0);
    check("t5_abort_addr",  bus.mem_addr,  0);
    init    = 1'b0;
    bus.req = 1'b1;
    wr0     = wr_seen;
    bad     = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.ack !== 1'b0 || bus.mem_wr_en !== 1'b0) bad++;
    end
    check("t6_req_high_idle", bad, 0);
    check("t6_req_high_no_writes", wr_seen - wr0, 0);
    expect_success(7'h60, 7'h01);
    sb_on = 1'b1;
    launch_wait(142, "t6");
    check_meta("t6", 8'h60, 8'h01, 8'h00);
    check("t6_pt10", mem[PT_BASE + 10], 8'h2D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
